// File: rtl/cpu54_pkg.sv
// ============================================================================
// cpu54_pkg : shared fetch-state encoding, reset PC and IR field positions
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cpu54_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_VALID = 2'd3;

    localparam int IMM_LSB   = 0;
    localparam int IMM_MSB   = 15;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_MSB = 10;
    localparam int INDEX_LSB = 0;
    localparam int INDEX_MSB = 25;

endpackage

`default_nettype wire

// File: rtl/ifetch_ir_if.sv
// ============================================================================
// ifetch_ir_if : instruction-memory read channel (req/gnt + rvalid/rdata)
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface ifetch_ir_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_ir_fields.sv
// ============================================================================
// ir_fields : combinational slicer of the IR into extender/jump fields
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ir_fields
    import cpu54_pkg::*;
(
    input  wire logic [31:0] ir,
    output logic      [15:0] imm16,
    output logic      [4:0]  shamt,
    output logic      [25:0] instr_index
);
    assign imm16       = ir[IMM_MSB:IMM_LSB];
    assign shamt       = ir[SHAMT_MSB:SHAMT_LSB];
    assign instr_index = ir[INDEX_MSB:INDEX_LSB];
endmodule

`default_nettype wire

// File: rtl/ifetch_ir.sv
// ============================================================================
// ifetch_ir : multicycle fetch stage - PC, one imem read per request, IR latch
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ifetch_ir
    import cpu54_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          fetch_start,
    input  wire logic          pc_load,
    input  wire logic [AW-1:0] pc_target,
    ifetch_ir_if.master        imem,
    output logic               busy,
    output logic               ir_valid,
    output logic [31:0]        ir,
    output logic [15:0]        imm16,
    output logic [4:0]         shamt,
    output logic [25:0]        instr_index,
    output logic [3:0]         pc_hi4,
    output logic [AW-1:0]      pc_plus4,
    output logic               err_sticky
);
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_ir;
    logic          r_err;
    logic          w_req;
    logic          w_busy;
    logic          w_ir_valid;
    logic          w_load_window;
    logic          w_capture;

    assign w_load_window = (r_state == c_ST_IDLE) || (r_state == c_ST_VALID);
    assign w_capture     = (r_state == c_ST_WAIT) && imem.imem_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rvalid is only looked at in WAIT, so stale responses elsewhere fall through
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (fetch_start)        w_state_nxt = c_ST_REQ;
            c_ST_REQ:   if (imem.imem_gnt)      w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (imem.imem_rvalid)   w_state_nxt = c_ST_VALID;
            c_ST_VALID: if (fetch_start)        w_state_nxt = c_ST_REQ;
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_req      = 1'b0;
        w_busy     = 1'b0;
        w_ir_valid = 1'b0;
        case (r_state)
            c_ST_REQ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
            end
            c_ST_WAIT:  w_busy     = 1'b1;
            c_ST_VALID: w_ir_valid = 1'b1;
            default: ;
        endcase
    end

    // A load in the fetch-start cycle lands on the same edge that enters REQ,
    // so the request address already reflects the new target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_ir  <= 32'h0;
            r_err <= 1'b0;
        end else begin
            if (pc_load) begin
                if (w_load_window) begin
                    r_pc <= {pc_target[AW-1:2], 2'b00};
                    if (pc_target[1:0] != 2'b00) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_capture) begin
                r_ir <= imem.imem_rdata;
                r_pc <= r_pc + AW'(4);
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign busy           = w_busy;
    assign ir_valid       = w_ir_valid;
    assign ir             = r_ir;
    assign pc_plus4       = r_pc;
    assign pc_hi4         = r_pc[AW-1:AW-4];
    assign err_sticky     = r_err;

    ir_fields u_ir_fields (
        .ir          (r_ir),
        .imm16       (imm16),
        .shamt       (shamt),
        .instr_index (instr_index)
    );
endmodule

`default_nettype wire

// File: tb/tb_ifetch_ir.sv
// ============================================================================
// tb_ifetch_ir : directed + randomized checks of ifetch_ir against a
//                transaction-level PC/IR model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_ir;
    import cpu54_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        busy;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [25:0] instr_index;
    logic [3:0]  pc_hi4;
    logic [31:0] pc_plus4;
    logic        err_sticky;

    ifetch_ir_if #(.AW(32)) imem_bus ();

    ifetch_ir #(.AW(32), .RESET_PC(32'h0040_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .imem        (imem_bus),
        .busy        (busy),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .imm16       (imm16),
        .shamt       (shamt),
        .instr_index (instr_index),
        .pc_hi4      (pc_hi4),
        .pc_plus4    (pc_plus4),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_err;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_result();
        logic [31:0] v;
        v = m_ir;
        chk("ir", ir, v);
        chk("imm16", 32'(imm16), 32'(v[15:0]));
        chk("shamt", 32'(shamt), 32'(v[10:6]));
        chk("instr_index", 32'(instr_index), 32'(v[25:0]));
        chk("pc_plus4", pc_plus4, m_pc);
        chk("pc_hi4", 32'(pc_hi4), 32'(m_pc[31:28]));
        chk("err_sticky", 32'(err_sticky), 32'(m_err));
    endtask

    // One complete fetch transaction with gnt/rvalid stalls and optional
    // pc_load in the start cycle or during WAIT.
    task automatic fetch(input logic ld, input logic [31:0] tgt, input int gst,
                         input int rst_cnt, input logic [31:0] data, input logic wload);
        @(negedge clk);
        fetch_start = 1'b1;
        pc_load     = ld;
        pc_target   = tgt;
        if (ld) begin
            if (tgt[1:0] != 2'b00) m_err = 1'b1;
            m_pc = {tgt[31:2], 2'b00};
        end
        @(negedge clk);
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        for (int i = 0; i <= gst; i++) begin
            chk("req_held", 32'(imem_bus.imem_req), 32'd1);
            chk("req_addr", imem_bus.imem_addr, m_pc);
            chk("busy_req", 32'(busy), 32'd1);
            chk("valid_req", 32'(ir_valid), 32'd0);
            chk("ir_hold", ir, m_ir);
            if (i == gst) begin
                imem_bus.imem_gnt    = 1'b1;
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = ~data;
            end
            @(negedge clk);
        end
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        for (int i = 0; i < rst_cnt; i++) begin
            chk("req_wait", 32'(imem_bus.imem_req), 32'd0);
            chk("wait_addr", imem_bus.imem_addr, m_pc);
            chk("busy_wait", 32'(busy), 32'd1);
            chk("valid_wait", 32'(ir_valid), 32'd0);
            if (wload && i == 0) begin
                pc_load   = 1'b1;
                pc_target = $urandom;
                m_err     = 1'b1;
            end
            @(negedge clk);
            pc_load = 1'b0;
        end
        chk("busy_last", 32'(busy), 32'd1);
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = data;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        m_ir    = data;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
        chk("ir_valid", 32'(ir_valid), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("req_done", 32'(imem_bus.imem_req), 32'd0);
        check_result();
    endtask

    task automatic load_only(input logic [31:0] tgt);
        @(negedge clk);
        pc_load   = 1'b1;
        pc_target = tgt;
        if (tgt[1:0] != 2'b00) m_err = 1'b1;
        m_pc = {tgt[31:2], 2'b00};
        @(negedge clk);
        pc_load = 1'b0;
        chk("load_pc", pc_plus4, m_pc);
        chk("load_err", 32'(err_sticky), 32'(m_err));
        chk("load_valid", 32'(ir_valid), 32'(m_valid));
    endtask

    task automatic stray();
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = $urandom;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("stray_ir", ir, m_ir);
        chk("stray_valid", 32'(ir_valid), 32'(m_valid));
        chk("stray_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        int          gs;
        int          rs;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        m_pc    = 32'h0040_0000;
        m_ir    = 32'h0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        check_result();
        rst_n = 1'b1;

        fetch(1'b0, 32'h0, 0, 0, 32'h2408_FFFF, 1'b0);
        chk("t1_imm16", 32'(imm16), 32'h0000_FFFF);
        chk("t1_pc_plus4", pc_plus4, 32'h0040_0004);

        fetch(1'b0, 32'h0, 4, 3, $urandom, 1'b0);
        fetch(1'b1, 32'h0040_0100, 0, 0, $urandom, 1'b0);
        fetch(1'b1, 32'h0040_0102, 1, 1, $urandom, 1'b0);
        chk("t3_err", 32'(err_sticky), 32'd1);

        fetch(1'b0, 32'h0, 1, 2, 32'h0810_0040, 1'b1);
        chk("t4_index", 32'(instr_index), 32'h0010_0040);
        chk("t4_hi4", 32'(pc_hi4), 32'h0);
        stray();

        // Reset asserted mid-WAIT, then a stale rvalid around the release
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        imem_bus.imem_gnt = 1'b1;
        @(negedge clk);
        imem_bus.imem_gnt = 1'b0;
        chk("t5_busy_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_pc    = 32'h0040_0000;
        m_ir    = 32'h0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        chk("t5_req_drop", 32'(imem_bus.imem_req), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        check_result();
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        chk("t5_valid", 32'(ir_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        check_result();

        load_only(32'hFFFF_FFFC);
        fetch(1'b0, 32'h0, 0, 1, $urandom, 1'b0);
        chk("t6_wrap", pc_plus4, 32'h0);
        chk("t6_err", 32'(err_sticky), 32'd0);

        for (int n = 0; n < 40; n++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            gs = int'($urandom_range(0, 4));
            rs = int'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: load_only(tgt);
                1: stray();
                default: fetch($urandom_range(0, 2) == 0, tgt, gs, rs, $urandom,
                               (rs > 0) && ($urandom_range(0, 4) == 0));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
